// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit
//  Description : LEGv8 pipeline stage 5 (write-back).
//                Selects the ALU, load or link result, extracts and extends
//                load data, and drives the register-file write port, the EX
//                forwarding port and a retire counter. All outputs are
//                registered. A load whose memory data arrives late makes the
//                stage stall upstream (in_ready low) until mem_rvalid.
//
//  Ports       : clk, reset                  clock / async active-high reset
//                in_valid, in_ready          stage-4 handshake
//                in_rd, in_regwrite          destination and write flag
//                in_wbsel                    00 ALU, 01 MEM, 10 LINK, 11 ALU
//                in_alu, in_link             ALU result, PC+4
//                in_ldsize, in_ldsigned      load size and extension mode
//                mem_rdata, mem_rvalid       LSB-aligned load data and strobe
//                rf_we/rf_waddr/rf_wdata     register-file write port
//                fwd_valid/fwd_rd/fwd_data   forwarding copy of the write port
//                retired                     completed-instruction counter
//
//  Revision    : 1.0  initial release
// ============================================================================
module writeback_unit #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_regwrite,
    input  logic [1:0]            in_wbsel,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_link,
    input  logic [1:0]            in_ldsize,
    input  logic                  in_ldsigned,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      retired
);

    localparam logic [REG_ADDR_W-1:0] c_zero_reg = REG_ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]      c_cnt_one  = CNT_W'(1);
    localparam logic [1:0]            c_sel_mem  = 2'b01;
    localparam logic [1:0]            c_sel_link = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Metadata of a load parked in WAIT_MEM
    logic [REG_ADDR_W-1:0] r_lat_rd;
    logic                  r_lat_regwrite;
    logic [1:0]            r_lat_ldsize;
    logic                  r_lat_ldsigned;

    // Registered outputs
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]     r_rf_wdata;
    logic [CNT_W-1:0]      r_retired;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_latch;
    logic                  w_use_latched;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  w_regwrite;
    logic [1:0]            w_ldsize;
    logic                  w_ldsigned;
    logic                  w_is_load;
    logic [DATA_W-1:0]     w_word_ext;
    logic [DATA_W-1:0]     w_dword_ext;
    logic [DATA_W-1:0]     w_load_data;
    logic [DATA_W-1:0]     w_result;

    // in_ready depends on state only, so there is no in_valid -> in_ready path
    assign in_ready = (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_commit      = 1'b0;
        w_latch       = 1'b0;
        w_use_latched = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((in_wbsel == c_sel_mem) && !mem_rvalid) begin
                        w_latch      = 1'b1;
                        w_next_state = S_WAIT_MEM;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
            end
            S_WAIT_MEM: begin
                w_use_latched = 1'b1;
                if (mem_rvalid) begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Commit metadata: live inputs in IDLE, parked copy in WAIT_MEM
    // ------------------------------------------------------------------------
    assign w_rd       = w_use_latched ? r_lat_rd       : in_rd;
    assign w_regwrite = w_use_latched ? r_lat_regwrite : in_regwrite;
    assign w_ldsize   = w_use_latched ? r_lat_ldsize   : in_ldsize;
    assign w_ldsigned = w_use_latched ? r_lat_ldsigned : in_ldsigned;
    assign w_is_load  = w_use_latched || (in_wbsel == c_sel_mem);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_rd       <= '0;
            r_lat_regwrite <= 1'b0;
            r_lat_ldsize   <= 2'b00;
            r_lat_ldsigned <= 1'b0;
        end else if (w_latch) begin
            r_lat_rd       <= in_rd;
            r_lat_regwrite <= in_regwrite;
            r_lat_ldsize   <= in_ldsize;
            r_lat_ldsigned <= in_ldsigned;
        end
    end

    // ------------------------------------------------------------------------
    // Load extraction. On a 32-bit datapath a word already fills the whole
    // register, and the dword encoding collapses onto it.
    // ------------------------------------------------------------------------
    generate
        if (DATA_W > 32) begin : g_wide
            assign w_word_ext  = {{(DATA_W-32){w_ldsigned & mem_rdata[31]}},
                                  mem_rdata[31:0]};
            assign w_dword_ext = mem_rdata;
        end else begin : g_narrow
            assign w_word_ext  = mem_rdata;
            assign w_dword_ext = mem_rdata;
        end
    endgenerate

    always_comb begin
        w_load_data = w_dword_ext;
        case (w_ldsize)
            2'b00:   w_load_data = {{(DATA_W-8){w_ldsigned & mem_rdata[7]}},
                                    mem_rdata[7:0]};
            2'b01:   w_load_data = {{(DATA_W-16){w_ldsigned & mem_rdata[15]}},
                                    mem_rdata[15:0]};
            2'b10:   w_load_data = w_word_ext;
            default: w_load_data = w_dword_ext;
        endcase
    end

    always_comb begin
        w_result = in_alu;
        if (w_is_load) begin
            w_result = w_load_data;
        end else if (in_wbsel == c_sel_link) begin
            w_result = in_link;
        end
    end

    // ------------------------------------------------------------------------
    // Commit registers. Address/data hold between commits; write enable is a
    // single-cycle pulse. The counter counts every commit, XZR included.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_retired  <= '0;
        end else begin
            r_rf_we <= 1'b0;
            if (w_commit) begin
                r_rf_we    <= w_regwrite && (w_rd != c_zero_reg);
                r_rf_waddr <= w_rd;
                r_rf_wdata <= w_result;
                r_retired  <= r_retired + c_cnt_one;
            end
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign fwd_valid = r_rf_we;
    assign fwd_rd    = r_rf_waddr;
    assign fwd_data  = r_rf_wdata;
    assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_unit
//  Description : Directed bench for writeback_unit (DATA_W=64, CNT_W=4).
//                Expected commits are queued as stimulus is driven and popped
//                after each clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic [1:0]  in_wbsel;
    logic [63:0] in_alu;
    logic [63:0] in_link;
    logic [1:0]  in_ldsize;
    logic        in_ldsigned;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [3:0]  retired;

    writeback_unit #(
        .DATA_W     (64),
        .REG_ADDR_W (5),
        .ZERO_REG   (31),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_regwrite (in_regwrite),
        .in_wbsel    (in_wbsel),
        .in_alu      (in_alu),
        .in_link     (in_link),
        .in_ldsize   (in_ldsize),
        .in_ldsigned (in_ldsigned),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [3:0]  ret;
    } exp_t;

    exp_t       q[$];
    logic [3:0] exp_ret;
    int         errors;
    int         checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the commit that the stimulus just driven must produce.
    function automatic void push(input logic rw, input logic [4:0] rd, input logic [63:0] d);
        exp_t e;
        exp_ret = exp_ret + 4'd1;
        e.we    = rw && (rd != 5'd31);
        e.rd    = rd;
        e.data  = d;
        e.ret   = exp_ret;
        q.push_back(e);
    endfunction

    // One clock edge, then compare outputs against the queue head (or no commit).
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ".rf_we"},     {63'd0, rf_we},     {63'd0, e.we});
            chk({tag, ".fwd_valid"}, {63'd0, fwd_valid}, {63'd0, e.we});
            chk({tag, ".rf_waddr"},  {59'd0, rf_waddr},  {59'd0, e.rd});
            chk({tag, ".fwd_rd"},    {59'd0, fwd_rd},    {59'd0, e.rd});
            chk({tag, ".rf_wdata"},  rf_wdata,           e.data);
            chk({tag, ".fwd_data"},  fwd_data,           e.data);
            chk({tag, ".retired"},   {60'd0, retired},   {60'd0, e.ret});
        end else begin
            chk({tag, ".idle_we"},   {63'd0, rf_we},     64'd0);
            chk({tag, ".idle_fwd"},  {63'd0, fwd_valid}, 64'd0);
            chk({tag, ".idle_ret"},  {60'd0, retired},   {60'd0, exp_ret});
        end
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                            input logic [63:0] alu, input logic [63:0] link,
                            input logic [1:0] sz, input logic sgn,
                            input logic [63:0] rdata, input logic rv);
        in_valid    = 1'b1;
        in_rd       = rd;
        in_regwrite = rw;
        in_wbsel    = sel;
        in_alu      = alu;
        in_link     = link;
        in_ldsize   = sz;
        in_ldsigned = sgn;
        mem_rdata   = rdata;
        mem_rvalid  = rv;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".rf_we"},     {63'd0, rf_we},     64'd0);
        chk({tag, ".rf_waddr"},  {59'd0, rf_waddr},  64'd0);
        chk({tag, ".rf_wdata"},  rf_wdata,           64'd0);
        chk({tag, ".fwd_valid"}, {63'd0, fwd_valid}, 64'd0);
        chk({tag, ".fwd_rd"},    {59'd0, fwd_rd},    64'd0);
        chk({tag, ".fwd_data"},  fwd_data,           64'd0);
        chk({tag, ".retired"},   {60'd0, retired},   64'd0);
        chk({tag, ".in_ready"},  {63'd0, in_ready},  64'd1);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        exp_ret     = 4'd0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_rd       = 5'd0;
        in_regwrite = 1'b0;
        in_wbsel    = 2'b00;
        in_alu      = 64'd0;
        in_link     = 64'd0;
        in_ldsize   = 2'b00;
        in_ldsigned = 1'b0;
        mem_rdata   = 64'd0;
        mem_rvalid  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        reset = 1'b0;

        // ALU path, then a quiet cycle
        drive_op(5'd3, 1'b1, 2'b00, 64'h1234, 64'd0, 2'b00, 1'b0, 64'd0, 1'b0);
        push(1'b1, 5'd3, 64'h1234);
        tick("alu");
        idle();
        tick("alu_after");

        // XZR: no write, counter still advances; regwrite=0 likewise
        drive_op(5'd31, 1'b1, 2'b00, 64'hFF, 64'd0, 2'b00, 1'b0, 64'd0, 1'b0);
        push(1'b1, 5'd31, 64'hFF);
        tick("xzr");
        drive_op(5'd4, 1'b0, 2'b00, 64'hAA, 64'd0, 2'b00, 1'b0, 64'd0, 1'b0);
        push(1'b0, 5'd4, 64'hAA);
        tick("nowrite");

        // Loads with data available immediately, back to back
        drive_op(5'd5, 1'b1, 2'b01, 64'd0, 64'd0, 2'b00, 1'b1, 64'h80, 1'b1);
        push(1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80);
        tick("ldb_s");
        drive_op(5'd5, 1'b1, 2'b01, 64'd0, 64'd0, 2'b00, 1'b0, 64'h80, 1'b1);
        push(1'b1, 5'd5, 64'h80);
        tick("ldb_u");
        drive_op(5'd6, 1'b1, 2'b01, 64'd0, 64'd0, 2'b01, 1'b1, 64'h1234_8001, 1'b1);
        push(1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_8001);
        tick("ldh_s");
        drive_op(5'd8, 1'b1, 2'b01, 64'd0, 64'd0, 2'b10, 1'b1, 64'hDEAD_BEEF_8000_0000, 1'b1);
        push(1'b1, 5'd8, 64'hFFFF_FFFF_8000_0000);
        tick("ldw_s");
        drive_op(5'd8, 1'b1, 2'b01, 64'd0, 64'd0, 2'b10, 1'b0, 64'hDEAD_BEEF_8000_0000, 1'b1);
        push(1'b1, 5'd8, 64'h8000_0000);
        tick("ldw_u");
        drive_op(5'd9, 1'b1, 2'b01, 64'd0, 64'd0, 2'b11, 1'b1, 64'hDEAD_BEEF_8000_0000, 1'b1);
        push(1'b1, 5'd9, 64'hDEAD_BEEF_8000_0000);
        tick("ldd");

        // Link and reserved select
        drive_op(5'd30, 1'b1, 2'b10, 64'h11, 64'h100, 2'b00, 1'b0, 64'd0, 1'b0);
        push(1'b1, 5'd30, 64'h100);
        tick("link");
        drive_op(5'd2, 1'b1, 2'b11, 64'h55, 64'h100, 2'b00, 1'b0, 64'h77, 1'b1);
        push(1'b1, 5'd2, 64'h55);
        tick("sel11");

        // Stray mem_rvalid in IDLE is ignored
        idle();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h99;
        tick("stray_rvalid");
        chk("stray.in_ready", {63'd0, in_ready}, 64'd1);

        // Late memory: three stalled cycles with junk on the inputs
        drive_op(5'd7, 1'b1, 2'b01, 64'd0, 64'd0, 2'b01, 1'b1, 64'd0, 1'b0);
        tick("late_accept");
        chk("late.ready0", {63'd0, in_ready}, 64'd0);
        drive_op(5'd12, 1'b1, 2'b00, 64'h999, 64'd0, 2'b00, 1'b0, 64'hFF, 1'b0);
        tick("late_wait1");
        chk("late.ready1", {63'd0, in_ready}, 64'd0);
        tick("late_wait2");
        chk("late.ready2", {63'd0, in_ready}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_7FFF;
        push(1'b1, 5'd7, 64'h7FFF);
        tick("late_commit");
        chk("late.ready3", {63'd0, in_ready}, 64'd1);
        idle();
        tick("late_after");

        // Reset while waiting on memory
        drive_op(5'd10, 1'b1, 2'b01, 64'd0, 64'd0, 2'b11, 1'b0, 64'd0, 1'b0);
        tick("rst_accept");
        chk("rst.ready0", {63'd0, in_ready}, 64'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero_outputs("rst_wait");
        exp_ret = 4'd0;
        q.delete();
        @(negedge clk);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h55;
        tick("rst_stale_rvalid");
        idle();

        // 17 back-to-back link ops on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            drive_op(5'(i % 8 + 1), 1'b1, 2'b10, 64'h0, 64'h40, 2'b00, 1'b0, 64'd0, 1'b0);
            push(1'b1, 5'(i % 8 + 1), 64'h40);
            tick("wrap");
        end
        chk("wrap.final", {60'd0, retired}, 64'd1);
        idle();
        tick("end_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
